hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised DE-stage hazard and forwarding unit for the in-order MIPS pipeline. It compares each DE read port against every downstream write-back stage and selects the youngest valid producer as the forwarding source. It stalls DE when that producer's data is not yet available, or when the iterative divider is busy. It also owns the divider busy countdown and a saturating stall-cycle performance counter.

## Interface

Parameters:
- NRD, 2, number of DE register read ports
- NSTG, 3, number of forwarding stages; index 0 = EX (youngest), NSTG-1 = WB (oldest)
- AW, 5, register address width; register 0 is never a hazard
- DIV_LAT, 33, divider busy cycles per issue, ≥ 2
- SW, $clog2(NSTG+1), width of each forwarding-select field

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  pipeline clock
- rst  in  1  asynchronous active-high reset
- de_valid  in  1  DE holds a valid instruction
- is_j_or_b  in  1  DE instruction is a jump/branch; hazard check is enabled even if de_valid=0
- rd_en  in  NRD  per-port read enable
- rd_addr  in  NRD*AW  per-port read address; port p at [p*AW +: AW]
- stg_valid  in  NSTG  stage holds a valid instruction
- stg_wen  in  NSTG  stage writes the register file (OR of its byte enables)
- stg_waddr  in  NSTG*AW  per-stage destination register
- stg_ready  in  NSTG  stage's result is forwardable this cycle; 0 for a load before data return
- div_issue  in  1  DE instruction is DIV/DIVU
- rd_hilo  in  1  DE instruction reads HI/LO (MFHI/MFLO)
- flush  in  1  exception/interrupt flush
- fwd_sel  out  NRD*SW  per port: 0 = register file, k = stage k-1
- stall  out  1  hold DE and the stages before it; insert a bubble into EX
- pc_we  out  1  ~stall
- ir_we  out  1  ~stall
- div_busy  out  1  divider busy countdown is non-zero
- stall_cnt  out  32  saturating count of stalled cycles

## Operation

- chk = de_valid | is_j_or_b.
- Match m[p][s] = chk & rd_en[p] & (rd_addr[p] != 0) & stg_valid[s] & stg_wen[s] & (stg_waddr[s] == rd_addr[p]).
- Forwarding: fwd_sel[p] = s+1 for the lowest s with m[p][s]=1, otherwise 0. The youngest producer always wins. Older matches are masked.
- Data stall: stall_d = OR over p of (the winning stage for p has stg_ready=0). A not-ready older match hidden behind a ready younger match does not stall.
- Divider stall: stall_v = div_busy & (div_issue | rd_hilo) & chk.
- stall = (stall_d | stall_v) & ~flush & ~rst.
- Divider countdown cnt, width $clog2(DIV_LAT+1):
  - flush: load 0 (flush wins over issue).
  - Else div_issue & de_valid & ~stall: load DIV_LAT.
  - Else cnt != 0: decrement.
  - div_busy = (cnt != 0).
- Divider states: IDLE (cnt=0) and BUSY (cnt>0).
  - IDLE→BUSY on an accepted issue.
  - BUSY→IDLE when cnt reaches 0 or on flush.
  - BUSY→BUSY reload is impossible, because an issue while busy is stalled.
- stall_cnt: increments on every cycle with stall=1, saturates at 32'hFFFF_FFFF, and is cleared only by rst.

## Timing

- fwd_sel, stall, pc_we and ir_we are combinational from the current-cycle inputs and cnt. Zero latency.
- An issue accepted at edge t gives div_busy=1 for exactly DIV_LAT cycles, t+1 … t+DIV_LAT. It is 0 at t+DIV_LAT+1.
- A MFHI/MFLO in DE stalls through the last busy cycle and proceeds in the first cycle with div_busy=0.
- stall_cnt updates at the edge that ends a stalled cycle.
- Reset values while rst is high: cnt=0, div_busy=0, stall_cnt=0, stall=0, pc_we=1, ir_we=1. fwd_sel is combinational (0 when there are no matches).
- A reset asserted mid-divide clears cnt asynchronously.
- The pipeline keeps a stalled DE instruction's inputs stable, so the stall/forward decision is re-evaluated each cycle.

## Structure

- Shared package hazard_pkg holds:
  - the fwd_sel encoding constants (FWD_RF=0, stage k → k+1);
  - the default AW;
  - DIV_LAT_DEFAULT=33.
- One natural sub-module: div_busy_ctr, holding the countdown and the IDLE/BUSY logic.
- The per-port youngest-match priority encoder is a generate loop over NRD, not a separate module.

## Test plan

- EX writes r5, ready=1; DE reads r5 on port 0 → fwd_sel[0]=1, stall=0.
- EX is a load to r5 (ready=0), MEM also writes r5 (ready=1); DE reads r5 → stall=1, stall_cnt +1 per cycle. When EX becomes ready: stall=0, fwd_sel[0]=1.
- EX writes r0, MEM writes r7, WB writes r7 (all ready); DE reads r0 on port 0 and r7 on port 1 → fwd_sel[0]=0, fwd_sel[1]=2.
- DIV accepted at cycle 10, MFHI in DE at 11 with DIV_LAT=33 → stall=1 for cycles 11–43, stall=0 at 44, div_busy low from 44.
- DIV busy (cnt=20) and flush=1 → stall=0 that cycle, cnt=0 and div_busy=0 next cycle. Simultaneous flush and div_issue from idle → cnt stays 0.
- Force stall_cnt near saturation (run 2^32 stalls, or DUT-visible test override) → it holds 32'hFFFF_FFFF. Assert rst mid-divide → div_busy=0 and stall_cnt=0 immediately.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants and types for the DE-stage hazard / forwarding unit.
package hazard_pkg;

    // fwd_sel encoding: 0 selects the register file, stage k selects k+1
    localparam int FWD_RF          = 0;
    localparam int AW_DEFAULT      = 5;
    localparam int DIV_LAT_DEFAULT = 33;

    typedef enum logic {
        DIV_IDLE = 1'b0,
        DIV_BUSY = 1'b1
    } div_state_e;

    function automatic int fwd_code(input int stage);
        return stage + 1;
    endfunction

endpackage

// File: rtl/div_busy_ctr.sv
// Divider busy countdown: loads DIV_LAT on an accepted issue, counts down to idle.
module div_busy_ctr
    import hazard_pkg::*;
#(
    parameter int DIV_LAT = DIV_LAT_DEFAULT,
    parameter int CW      = $clog2(DIV_LAT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic issue,     // DIV accepted this cycle (already qualified by ~stall)
    output logic busy
);

    div_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // State and count registers; reset clears a divide in flight immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: flush beats issue, issue loads, otherwise count down
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = DIV_IDLE;
            cnt_d   = '0;
        end else if (issue) begin
            // In BUSY an issue is always stalled, so this is effectively IDLE->BUSY
            state_d = DIV_BUSY;
            cnt_d   = CW'(DIV_LAT);
        end else if (state_q == DIV_BUSY) begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = DIV_IDLE;
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// DE-stage hazard detection, youngest-producer forwarding select, divider
// interlock and saturating stall-cycle counter.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NRD     = 2,
    parameter int NSTG    = 3,
    parameter int AW      = AW_DEFAULT,
    parameter int DIV_LAT = DIV_LAT_DEFAULT,
    parameter int SW      = $clog2(NSTG + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              de_valid,
    input  logic              is_j_or_b,
    input  logic [NRD-1:0]    rd_en,
    input  logic [NRD*AW-1:0] rd_addr,
    input  logic [NSTG-1:0]   stg_valid,
    input  logic [NSTG-1:0]   stg_wen,
    input  logic [NSTG*AW-1:0] stg_waddr,
    input  logic [NSTG-1:0]   stg_ready,
    input  logic              div_issue,
    input  logic              rd_hilo,
    input  logic              flush,
    output logic [NRD*SW-1:0] fwd_sel,
    output logic              stall,
    output logic              pc_we,
    output logic              ir_we,
    output logic              div_busy,
    output logic [31:0]       stall_cnt
);

    logic           chk;
    logic [NRD-1:0] port_nrdy;
    logic           stall_v;
    logic           div_accept;
    logic [31:0]    stall_cnt_q, stall_cnt_d;

    // Branches/jumps resolve in DE, so they are checked even without de_valid
    assign chk = de_valid | is_j_or_b;

    for (genvar gp = 0; gp < NRD; gp++) begin : g_port
        logic [AW-1:0]   addr;
        logic [NSTG-1:0] match;
        logic [SW-1:0]   sel;
        logic            nrdy;

        assign addr = rd_addr[gp*AW +: AW];

        // Per-stage address match; r0 never creates a dependency
        always_comb begin
            match = '0;
            for (int s = 0; s < NSTG; s++) begin
                match[s] = chk & rd_en[gp] & (addr != '0) & stg_valid[s] & stg_wen[s]
                         & (stg_waddr[s*AW +: AW] == addr);
            end
        end

        // Priority encode: scan oldest to youngest so the youngest match wins;
        // only the winner's readiness matters for stalling
        always_comb begin
            sel  = SW'(FWD_RF);
            nrdy = 1'b0;
            for (int s = NSTG - 1; s >= 0; s--) begin
                if (match[s]) begin
                    sel  = SW'(fwd_code(s));
                    nrdy = ~stg_ready[s];
                end
            end
        end

        assign fwd_sel[gp*SW +: SW] = sel;
        assign port_nrdy[gp]        = nrdy;
    end

    assign stall_v    = div_busy & (div_issue | rd_hilo) & chk;
    assign stall      = ((|port_nrdy) | stall_v) & ~flush & ~rst;
    assign pc_we      = ~stall;
    assign ir_we      = ~stall;
    assign div_accept = div_issue & de_valid & ~stall;

    div_busy_ctr #(
        .DIV_LAT (DIV_LAT)
    ) u_div_busy_ctr (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .issue (div_accept),
        .busy  (div_busy)
    );

    // Stall-cycle counter: counts stalled cycles, sticks at all-ones
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    // Counter register, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with default parameters.
module tb_hazard_scoreboard;

    logic        clk;
    logic        rst;
    logic        de_valid, is_j_or_b;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic [2:0]  stg_valid, stg_wen, stg_ready;
    logic [14:0] stg_waddr;
    logic        div_issue, rd_hilo, flush;
    logic [3:0]  fwd_sel;
    logic        stall, pc_we, ir_we, div_busy;
    logic [31:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    hazard_scoreboard dut (
        .clk       (clk),
        .rst       (rst),
        .de_valid  (de_valid),
        .is_j_or_b (is_j_or_b),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .stg_valid (stg_valid),
        .stg_wen   (stg_wen),
        .stg_waddr (stg_waddr),
        .stg_ready (stg_ready),
        .div_issue (div_issue),
        .rd_hilo   (rd_hilo),
        .flush     (flush),
        .fwd_sel   (fwd_sel),
        .stall     (stall),
        .pc_we     (pc_we),
        .ir_we     (ir_we),
        .div_busy  (div_busy),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clr_in();
        de_valid = 0; is_j_or_b = 0; rd_en = 0; rd_addr = 0;
        stg_valid = 0; stg_wen = 0; stg_waddr = 0; stg_ready = 0;
        div_issue = 0; rd_hilo = 0; flush = 0;
    endtask

    task automatic set_stg(input int s, input logic [4:0] a, input logic r);
        stg_valid[s] = 1'b1;
        stg_wen[s]   = 1'b1;
        stg_waddr[s*5 +: 5] = a;
        stg_ready[s] = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int n;

    initial begin
        clr_in();
        rst = 1'b1;
        #12;
        check("rst_stall", stall, 0);
        check("rst_pc_we", pc_we, 1);
        check("rst_ir_we", ir_we, 1);
        check("rst_div_busy", div_busy, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_fwd_sel", fwd_sel, 0);
        rst = 1'b0;
        tick();

        // EX writes r5 ready; DE reads r5 on port 0
        set_stg(0, 5'd5, 1'b1);
        de_valid = 1; rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
        #1;
        check("ex_fwd_sel", fwd_sel, 4'h1);
        check("ex_stall", stall, 0);

        // EX load r5 not ready, MEM r5 ready -> stall on youngest
        set_stg(0, 5'd5, 1'b0);
        set_stg(1, 5'd5, 1'b1);
        #1;
        check("ld_stall", stall, 1);
        check("ld_pc_we", pc_we, 0);
        check("ld_fwd_sel", fwd_sel, 4'h1);
        tick(); tick(); tick();
        check("ld_stall_cnt3", stall_cnt, 3);
        stg_ready[0] = 1'b1;
        #1;
        check("ld_ready_stall", stall, 0);
        check("ld_ready_fwd", fwd_sel, 4'h1);
        stg_ready[1] = 1'b0;   // older not-ready producer is masked
        #1;
        check("masked_old_stall", stall, 0);
        tick();
        check("ld_stall_cnt_hold", stall_cnt, 3);

        // r0 never hazards; r7 youngest in MEM
        clr_in();
        set_stg(0, 5'd0, 1'b1);
        set_stg(1, 5'd7, 1'b1);
        set_stg(2, 5'd7, 1'b1);
        de_valid = 1; rd_en = 2'b11; rd_addr = {5'd7, 5'd0};
        #1;
        check("r0_r7_fwd", fwd_sel, 4'h8);
        de_valid = 0;
        #1;
        check("nochk_fwd", fwd_sel, 4'h0);
        is_j_or_b = 1;
        #1;
        check("jb_fwd", fwd_sel, 4'h8);
        rd_en = 2'b01;
        #1;
        check("rden_off_fwd", fwd_sel, 4'h0);
        stg_waddr[14:10] = 5'd9; rd_en = 2'b11;   // WB no longer matches, MEM still wins
        set_stg(1, 5'd3, 1'b1);                   // MEM moves away: WB gone too -> 0
        #1;
        check("nomatch_fwd", fwd_sel, 4'h0);

        // DIV issue then MFHI: stalls exactly DIV_LAT cycles
        clr_in();
        de_valid = 1; div_issue = 1;
        #1;
        check("div_issue_nostall", stall, 0);
        tick();
        check("div_busy_set", div_busy, 1);
        div_issue = 0; rd_hilo = 1;
        n = 0;
        while (stall && n < 100) begin
            n++;
            tick();
        end
        check("mfhi_stall_cycles", n, 33);
        check("mfhi_busy_done", div_busy, 0);
        check("stall_cnt_after_div", stall_cnt, 36);

        // Flush mid-divide at cnt=20
        rd_hilo = 0; div_issue = 1;
        tick();
        div_issue = 0;
        repeat (13) tick();
        rd_hilo = 1;
        #1;
        check("cnt20_stall", stall, 1);
        check("cnt20_busy", div_busy, 1);
        flush = 1;
        #1;
        check("flush_stall", stall, 0);
        tick();
        check("flush_busy", div_busy, 0);
        flush = 0;
        #1;
        check("post_flush_stall", stall, 0);

        // Flush beats a simultaneous issue from idle
        rd_hilo = 0; div_issue = 1; flush = 1;
        tick();
        check("flush_issue_busy", div_busy, 0);
        flush = 0; div_issue = 0;

        // Saturation: preload near all-ones, then stall through it
        clr_in();
        set_stg(0, 5'd5, 1'b0);
        de_valid = 1; rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
        force dut.stall_cnt_q = 32'hFFFF_FFFD;
        #1;
        release dut.stall_cnt_q;
        #1;
        check("sat_preload", stall_cnt, 32'hFFFF_FFFD);
        tick();
        check("sat_fe", stall_cnt, 32'hFFFF_FFFE);
        repeat (3) tick();
        check("sat_hold", stall_cnt, 32'hFFFF_FFFF);

        // Reset mid-divide clears asynchronously
        clr_in();
        de_valid = 1; div_issue = 1;
        tick();
        div_issue = 0;
        tick();
        check("pre_rst_busy", div_busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_busy", div_busy, 0);
        check("async_rst_cnt", stall_cnt, 0);
        check("async_rst_pc_we", pc_we, 1);
        rst = 1'b0;
        tick();
        check("post_rst_busy", div_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
